fir_mch_filter: RTL and testbench
=================================

FIR_MCH_FILTER -- requirements
Module: fir_mch_filter

Interface
REQ-001 Parameter N, default 32: taps per channel, N >= 2.
REQ-002 Parameter WIDTH, default 14: signed input sample width.
REQ-003 Parameter COEF_WIDTH, default 16: signed coefficient width.
REQ-004 Parameter CH, default 2: channel count, CH >= 1; CH_W = max(1, clog2(CH)).
REQ-005 Parameter SHIFT, default 15: right-shift applied before saturation (FIR_SAT_EN only).
REQ-006 Derived ACC_W = WIDTH + COEF_WIDTH + clog2(N).
REQ-007 The block SHALL have one clock, with a synchronous, active-high reset.
REQ-008 clk  in  1  sole clock; all state updates on rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 din  in  WIDTH  signed sample.
REQ-011 in_ch  in  CH_W  channel tag of din.
REQ-012 in_valid / in_ready  in / out  1  input handshake; transfer on edge with both high.
REQ-013 dout  out  ACC_W  signed filter result.
REQ-014 out_ch  out  CH_W  channel tag of dout.
REQ-015 out_valid / out_ready  out / in  1  output handshake.
REQ-016 coef_we  in  1  coefficient write strobe.
REQ-017 coef_addr  in  clog2(N)  tap index; coef_data  in  COEF_WIDTH  signed value.
REQ-018 coef_err  out  1  one-cycle pulse: write rejected.
REQ-019 ch_err  out  1  one-cycle pulse: sample with in_ch >= CH discarded.

Function
REQ-020 FSM states IDLE, MAC, LOAD, OUT; in_ready SHALL be high only in IDLE.
REQ-021 IDLE, transfer with in_ch < CH: shift that channel's N-deep delay line (din into tap 0, tap N-1 dropped), clear accumulator, tap index = 0, latch channel, go to MAC.
REQ-022 IDLE, transfer with in_ch >= CH: no delay line change, stay IDLE, pulse ch_err next cycle.
REQ-023 MAC: one product x[i]*h[i] added to ACC_W-bit accumulator per cycle, i = 0..N-1; after i = N-1 go to LOAD.
REQ-024 Coefficients SHALL be shared by all channels; delay lines SHALL be per-channel and never interact.
REQ-025 LOAD: register dout and out_ch, set out_valid, go to OUT; out_valid first visible N+1 cycles after the accepting edge.
REQ-026 OUT: dout, out_ch, out_valid held stable until the edge with out_ready high; that edge clears out_valid and returns to IDLE (earliest next accept one cycle later).
REQ-027 Throughput: at most one sample per N+3 cycles with out_ready held high.
REQ-028 coef_we in IDLE SHALL write coef[coef_addr] on that edge, and takes effect for the next accepted sample; simultaneous with an input transfer, the write completes first.
REQ-029 coef_we outside IDLE: write dropped, coef_err pulsed next cycle, coefficients unchanged.
REQ-030 Accumulation SHALL be full-precision signed; no overflow for any inputs at ACC_W.

Reset
REQ-031 Reset, including mid-MAC or mid-OUT, SHALL force IDLE, clear accumulator, all delay lines, dout, out_ch, out_valid, coef_err, ch_err.
REQ-032 Reset SHALL restore coef[0] = 1, all other coefficients 0 (unity pass-through).
REQ-033 in_ready SHALL be low while reset is high and high the first cycle after release.

Configuration
REQ-034 Macro FIR_SAT_EN: when defined, LOAD SHALL compute acc >>> SHIFT, round half up, saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1], sign-extend to ACC_W.
REQ-035 Without FIR_SAT_EN, dout SHALL equal the raw accumulator; SHIFT unused.

Verification
REQ-036 After reset, ch0 din = 100, then zeros -> first dout = 100, next 31 outputs 0 (no FIR_SAT_EN).
REQ-037 All 32 coef = 1, 32 ch0 samples of 1000 -> 32nd dout = 32000, out_ch = 0.
REQ-038 Interleave ch0 = 500 and ch1 = -7 impulses, default coefs -> ch0 outputs 500, ch1 outputs -7, no cross-talk.
REQ-039 out_ready low 5 cycles in OUT -> dout stable, in_ready low; out_ready high -> in_ready high one cycle later.
REQ-040 coef_we during MAC, addr 0, data 9 -> coef_err pulse; next impulse 100 still yields 100.
REQ-041 FIR_SAT_EN, SHIFT = 0, all coef 32767, 32 samples of 8191 -> dout = 8191; all -8192 -> dout = -8192.

Source files
------------

// File: rtl/fir_mch_filter.sv
// Multi-channel FIR: shared coefficients, per-channel delay lines, one MAC per cycle.
// Optional FIR_SAT_EN macro adds shift, round-half-up and saturation to WIDTH bits.
module fir_mch_filter #(
   parameter int N          = 32,
   parameter int WIDTH      = 14,
   parameter int COEF_WIDTH = 16,
   parameter int CH         = 2,
   parameter int SHIFT      = 15,
   localparam int CH_W      = (CH > 1) ? $clog2(CH) : 1,
   localparam int AW        = $clog2(N),
   localparam int ACC_W     = WIDTH + COEF_WIDTH + $clog2(N)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic signed [WIDTH-1:0]      din,
   input  logic        [CH_W-1:0]       in_ch,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic signed [ACC_W-1:0]      dout,
   output logic        [CH_W-1:0]       out_ch,
   output logic                         out_valid,
   input  logic                         out_ready,
   input  logic                         coef_we,
   input  logic        [AW-1:0]         coef_addr,
   input  logic signed [COEF_WIDTH-1:0] coef_data,
   output logic                         coef_err,
   output logic                         ch_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_LOAD = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   logic [1:0]                   state;
   logic signed [WIDTH-1:0]      dline [CH][N];
   logic signed [COEF_WIDTH-1:0] coef [N];
   logic signed [ACC_W-1:0]      acc;
   logic [AW-1:0]                idx;
   logic [CH_W-1:0]              ch_q;
   logic signed [WIDTH+COEF_WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]      res;
   logic                         take;
   logic                         ch_ok;
   logic                         addr_ok;

   assign in_ready = (state == S_IDLE) && !reset;
   assign take     = in_valid && in_ready;
   assign ch_ok    = {1'b0, in_ch} < (CH_W+1)'(CH);
   assign addr_ok  = {1'b0, coef_addr} < (AW+1)'(N);
   assign prod     = dline[ch_q][idx] * coef[idx];

`ifdef FIR_SAT_EN
   localparam logic signed [ACC_W:0] RND  = ((ACC_W+1)'(1) << SHIFT) >> 1;
   localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << (WIDTH-1)) - 1);
   localparam logic signed [ACC_W:0] MINV = -MAXV - 1;

   logic signed [ACC_W:0] rsum;
   logic signed [ACC_W:0] shv;

   // One guard bit so the rounding add cannot wrap.
   assign rsum = {acc[ACC_W-1], acc} + RND;
   assign shv  = rsum >>> SHIFT;

   always_comb begin
      res = shv[ACC_W-1:0];
      if (shv > MAXV)
         res = MAXV[ACC_W-1:0];
      else if (shv < MINV)
         res = MINV[ACC_W-1:0];
   end
`else
   assign res = acc;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         acc       <= '0;
         idx       <= '0;
         ch_q      <= '0;
         dout      <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         coef_err  <= 1'b0;
         ch_err    <= 1'b0;
         for (int c = 0; c < CH; c++)
            for (int t = 0; t < N; t++)
               dline[c][t] <= '0;
         for (int t = 0; t < N; t++)
            coef[t] <= (t == 0) ? COEF_WIDTH'(1) : '0;
      end else begin
         coef_err <= 1'b0;
         ch_err   <= 1'b0;
         if (coef_we) begin
            if (state == S_IDLE && addr_ok)
               coef[coef_addr] <= coef_data;
            else
               coef_err <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (take) begin
                  if (ch_ok) begin
                     for (int c = 0; c < CH; c++) begin
                        if (in_ch == CH_W'(c)) begin
                           dline[c][0] <= din;
                           for (int t = 1; t < N; t++)
                              dline[c][t] <= dline[c][t-1];
                        end
                     end
                     acc   <= '0;
                     idx   <= '0;
                     ch_q  <= in_ch;
                     state <= S_MAC;
                  end else begin
                     ch_err <= 1'b1;
                  end
               end
            end
            S_MAC: begin
               acc <= acc + ACC_W'(prod);
               idx <= idx + 1'b1;
               if (idx == AW'(N-1))
                  state <= S_LOAD;
            end
            S_LOAD: begin
               dout      <= res;
               out_ch    <= ch_q;
               out_valid <= 1'b1;
               state     <= S_OUT;
            end
            default: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mch_filter.sv
// Directed bench for fir_mch_filter: impulses, sums, interleave, backpressure, errors.
// Builds with or without FIR_SAT_EN; the saturation test runs only when it is defined.
module tb_fir_mch_filter;

   localparam int N     = 32;
   localparam int WIDTH = 14;
   localparam int CW    = 16;
   localparam int CH    = 3;
`ifdef FIR_SAT_EN
   localparam int SHIFT = 0;
`else
   localparam int SHIFT = 15;
`endif
   localparam int CH_W  = 2;
   localparam int AW    = 5;
   localparam int ACC_W = 35;

   logic                    clk;
   logic                    reset;
   logic signed [WIDTH-1:0] din;
   logic [CH_W-1:0]         in_ch;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [ACC_W-1:0] dout;
   logic [CH_W-1:0]         out_ch;
   logic                    out_valid;
   logic                    out_ready;
   logic                    coef_we;
   logic [AW-1:0]           coef_addr;
   logic signed [CW-1:0]    coef_data;
   logic                    coef_err;
   logic                    ch_err;

   int total;
   int bad;

   fir_mch_filter #(
      .N(N), .WIDTH(WIDTH), .COEF_WIDTH(CW), .CH(CH), .SHIFT(SHIFT)
   ) dut (
      .clk(clk), .reset(reset),
      .din(din), .in_ch(in_ch), .in_valid(in_valid), .in_ready(in_ready),
      .dout(dout), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .coef_err(coef_err), .ch_err(ch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic push(input logic [CH_W-1:0] c, input logic signed [WIDTH-1:0] d);
      int w;
      @(negedge clk);
      in_ch = c; din = d; in_valid = 1'b1; w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL push_wait: in_ready=%b required=1", in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic pull(input bit ack, output logic signed [ACC_W-1:0] d,
                       output logic [CH_W-1:0] c, output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      d = dout;
      c = out_ch;
      if (ack) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic wcoef(input int a, input int v);
      @(negedge clk);
      coef_we = 1'b1; coef_addr = AW'(a); coef_data = CW'(v);
      @(posedge clk);
      #1 coef_we = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total++;
      if ({in_ready, out_valid, coef_err, ch_err} !== 4'b0000 || dout !== '0) begin
         bad++;
         $display("FAIL reset_outputs: rdy/vld/cerr/cherr=%b dout=%0d required 0000 0",
                  {in_ready, out_valid, coef_err, ch_err}, dout);
      end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release: in_ready=%b required=1", in_ready);
      end
   endtask

   task automatic test_impulse();
      logic signed [ACC_W-1:0] d;
      logic [CH_W-1:0] c;
      int cyc;
      do_reset();
      push(0, 100);
      pull(1, d, c, cyc);
      total++;
      if (d !== ACC_W'(100) || c !== 2'd0 || cyc !== N+1) begin
         bad++;
         $display("FAIL impulse_first: dout=%0d ch=%0d lat=%0d required 100 0 %0d", d, c, cyc, N+1);
      end
      for (int k = 0; k < N-1; k++) begin
         push(0, 0);
         pull(1, d, c, cyc);
         total++;
         if (d !== '0) begin
            bad++;
            $display("FAIL impulse_tail[%0d]: dout=%0d required 0", k, d);
         end
      end
   endtask

   task automatic test_coef_sum();
      logic signed [ACC_W-1:0] d;
      logic [CH_W-1:0] c;
      int cyc;
      do_reset();
      for (int t = 0; t < N; t++)
         wcoef(t, 1);
      @(negedge clk);
      total++;
      if (coef_err !== 1'b0) begin
         bad++;
         $display("FAIL coef_idle_write: coef_err=%b required=0", coef_err);
      end
      for (int k = 1; k <= N; k++) begin
         push(0, 1000);
         pull(1, d, c, cyc);
         if (k == 1 || k == 16 || k == N) begin
            total++;
            if (d !== ACC_W'(1000*k) || c !== 2'd0) begin
               bad++;
               $display("FAIL coef_sum[%0d]: dout=%0d ch=%0d required %0d 0", k, d, c, 1000*k);
            end
         end
      end
   endtask

   task automatic test_interleave();
      int chs [10] = '{0, 1, 0, 1, 0, 1, 2, 0, 1, 2};
      int ins [10] = '{500, -7, 0, 0, 500, -7, 3, 0, 0, 0};
      int exs [10] = '{500, -7, 0, 0, 500, -7, 3, 1000, -14, 6};
      logic signed [ACC_W-1:0] d;
      logic [CH_W-1:0] c;
      int cyc;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            do_reset();
            wcoef(1, 2);
         end
         push(CH_W'(chs[i]), WIDTH'(ins[i]));
         pull(1, d, c, cyc);
         total++;
         if (d !== ACC_W'(exs[i]) || c !== CH_W'(chs[i])) begin
            bad++;
            $display("FAIL interleave[%0d]: dout=%0d ch=%0d required %0d %0d",
                     i, d, c, exs[i], chs[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic signed [ACC_W-1:0] d;
      logic [CH_W-1:0] c;
      int cyc;
      do_reset();
      push(0, 55);
      pull(0, d, c, cyc);
      total++;
      if (d !== ACC_W'(55) || cyc !== N+1) begin
         bad++;
         $display("FAIL bp_first: dout=%0d lat=%0d required 55 %0d", d, cyc, N+1);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || dout !== ACC_W'(55) || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold[%0d]: vld=%b dout=%0d rdy=%b required 1 55 0",
                     k, out_valid, dout, in_ready);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_release: rdy=%b vld=%b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_coef_err();
      logic signed [ACC_W-1:0] d;
      logic [CH_W-1:0] c;
      int cyc;
      do_reset();
      push(0, 100);
      coef_we = 1'b1; coef_addr = '0; coef_data = CW'(9);
      @(posedge clk);
      #1 coef_we = 1'b0;
      @(negedge clk);
      total++;
      if (coef_err !== 1'b1) begin
         bad++;
         $display("FAIL coef_err_pulse: coef_err=%b required=1", coef_err);
      end
      @(negedge clk);
      total++;
      if (coef_err !== 1'b0) begin
         bad++;
         $display("FAIL coef_err_width: coef_err=%b required=0", coef_err);
      end
      pull(1, d, c, cyc);
      push(0, 100);
      pull(1, d, c, cyc);
      total++;
      if (d !== ACC_W'(100)) begin
         bad++;
         $display("FAIL coef_err_kept: dout=%0d required 100", d);
      end
   endtask

   task automatic test_ch_err();
      logic signed [ACC_W-1:0] d;
      logic [CH_W-1:0] c;
      int cyc;
      do_reset();
      push(3, 77);
      total++;
      if (ch_err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL ch_err_pulse: cherr=%b vld=%b rdy=%b required 1 0 1",
                  ch_err, out_valid, in_ready);
      end
      @(negedge clk);
      total++;
      if (ch_err !== 1'b0) begin
         bad++;
         $display("FAIL ch_err_width: ch_err=%b required=0", ch_err);
      end
      push(2, 5);
      pull(1, d, c, cyc);
      total++;
      if (d !== ACC_W'(5) || c !== 2'd2) begin
         bad++;
         $display("FAIL ch_err_after: dout=%0d ch=%0d required 5 2", d, c);
      end
   endtask

   task automatic test_mid_reset();
      logic signed [ACC_W-1:0] d;
      logic [CH_W-1:0] c;
      int cyc;
      do_reset();
      push(0, 100);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL midmac_rdy: in_ready=%b required=0", in_ready);
      end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL midmac_state: vld=%b rdy=%b required 0 1", out_valid, in_ready);
      end
      wcoef(1, 1);
      push(0, 0);
      pull(1, d, c, cyc);
      total++;
      if (d !== '0 || cyc !== N+1) begin
         bad++;
         $display("FAIL midmac_line: dout=%0d lat=%0d required 0 %0d", d, cyc, N+1);
      end
      push(0, 42);
      pull(0, d, c, cyc);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++;
      if (out_valid !== 1'b0 || dout !== '0) begin
         bad++;
         $display("FAIL midout_clear: vld=%b dout=%0d required 0 0", out_valid, dout);
      end
      push(0, 7);
      pull(1, d, c, cyc);
      push(0, 0);
      pull(1, d, c, cyc);
      total++;
      if (d !== '0) begin
         bad++;
         $display("FAIL reset_coefs: dout=%0d required 0", d);
      end
   endtask

`ifdef FIR_SAT_EN
   task automatic test_sat();
      logic signed [ACC_W-1:0] d;
      logic [CH_W-1:0] c;
      int cyc;
      do_reset();
      for (int t = 0; t < N; t++)
         wcoef(t, 32767);
      for (int k = 0; k < N; k++) begin
         push(0, 8191);
         pull(1, d, c, cyc);
      end
      total++;
      if (d !== ACC_W'(8191)) begin
         bad++;
         $display("FAIL sat_pos: dout=%0d required 8191", d);
      end
      for (int k = 0; k < N; k++) begin
         push(0, -8192);
         pull(1, d, c, cyc);
      end
      total++;
      if (d !== ACC_W'(-8192)) begin
         bad++;
         $display("FAIL sat_neg: dout=%0d required -8192", d);
      end
   endtask
`endif

   initial begin
      total = 0; bad = 0;
      reset = 1'b1; din = '0; in_ch = '0; in_valid = 1'b0; out_ready = 1'b0;
      coef_we = 1'b0; coef_addr = '0; coef_data = '0;
      test_reset();
      test_impulse();
`ifndef FIR_SAT_EN
      test_coef_sum();
`endif
      test_interleave();
      test_backpressure();
      test_coef_err();
      test_ch_err();
      test_mid_reset();
`ifdef FIR_SAT_EN
      test_sat();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
